bus_trace_capture: RTL and testbench
====================================

Name: bus_trace_capture

Overview:
- Logic-analyser stage downstream of the CPU bus-cycle trace.
- Samples one 6502 bus cycle per cpu_clken: address, data, R/W, SYNC.
- Holds pre-trigger history in a circular block RAM, captures a fixed post-trigger window, then streams the record oldest-first as a byte stream.
- The byte stream feeds a UART transmitter or host link.

Parameters:
DEPTH_LOG2, 9, log2 of buffer entries (512 x 26-bit).
POST_SAMPLES, 256, samples captured after and excluding the trigger sample; legal range 0 .. 2^DEPTH_LOG2-1.

Ports:
clk  input  1  system clock (cpu_clk domain)
reset_n  input  1  synchronous reset, active low
clken  input  1  one-cycle strobe; bus_* valid when high
bus_addr  input  16  CPU address for this bus cycle
bus_data  input  8  data written or read this cycle
bus_rnw  input  1  1 = read, 0 = write
bus_sync  input  1  opcode-fetch cycle
arm  input  1  single-cycle pulse; starts capture from IDLE
abort  input  1  return to IDLE immediately
trig_addr  input  16  trigger address
trig_mask  input  16  1 = bit compared
out_data  output  8  stream byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts byte when valid && ready
busy  output  1  high in any state except IDLE
triggered  output  1  high from trigger sample until return to IDLE

Behaviour:
- One clock (clk). Reset is synchronous, active-low (reset_n).
- Reset values: state IDLE; out_valid 0; out_data 8'h00; busy 0; triggered 0; wr_ptr 0; fill count 0; post counter 0.
- Reset mid-operation behaves like abort. Buffer RAM contents are not cleared.
- Sample word: {bus_addr, bus_data, bus_rnw, bus_sync}.
- A sample is written only on a clk edge with clken=1 in ARMED or POST.
- Each write sets wr_ptr <= wr_ptr+1, wrapping modulo 2^DEPTH_LOG2.
- Fill count increments per write and saturates at 2^DEPTH_LOG2.
- Trigger match: ((bus_addr ^ trig_addr) & trig_mask) == 0. trig_mask = 0 triggers on the first sample.
- IDLE:
  - arm=1 -> ARMED; wr_ptr and fill count cleared.
  - A clken coinciding with the arm cycle is not captured.
- ARMED:
  - Captures every clken.
  - A captured sample that matches the trigger -> POST; triggered=1; post counter loaded with POST_SAMPLES.
  - If POST_SAMPLES=0 -> DUMP directly.
- POST:
  - Each capture decrements the post counter. The capture that makes it 0 -> DUMP.
  - Trigger matches are ignored.
- DUMP:
  - Start entry = fill<2^DEPTH_LOG2 ? 0 : wr_ptr. Entry count = fill.
  - Each entry is emitted as 4 bytes, in order: addr[15:8], addr[7:0], data, {sync, rnw, 6'b000000}.
  - Block RAM read is synchronous, 1-cycle latency. The first out_valid asserts no later than 3 clk after entering DUMP.
  - out_data must hold stable while out_valid && !out_ready.
  - With out_ready held high, sustained throughput is 1 byte per clk, except at most 1 bubble per entry.
  - After the last byte is accepted -> IDLE, same cycle out_valid <= 0.
  - clken is ignored in DUMP.
- abort=1 in any state -> IDLE next clk; out_valid 0; triggered 0. abort has priority over arm, trigger and handshake.
- arm outside IDLE is ignored.
- Simultaneous trigger match and arm in IDLE: arm only.
- Post counter width is DEPTH_LOG2 bits.
- Since POST_SAMPLES < depth, the trigger sample stays in the dumped window.

Test Plan:
- Arm, trig_mask=16'hFFFF, trig_addr=16'hC000, feed 10 clken samples with addr 0..8 then C000, POST_SAMPLES=2, two more samples (D000, D001) -> 12 entries dumped starting 0x0000, 48 bytes. Entry 9 bytes = C0 00 dd ff, last entry D0 01.
- DEPTH_LOG2=4, POST_SAMPLES=3, 40 samples addr=n before trigger at addr=0x1234 -> exactly 16 entries. First dumped addr = trigger index-12. Trigger entry is 13th. Last = trigger+3.
- Backpressure: out_ready toggling 1/0 every 3 clk during dump -> no byte lost or duplicated; out_data is constant while stalled; sequence equals the out_ready=1 run.
- abort asserted mid-POST, then mid-DUMP with out_valid=1 -> next clk busy=0, out_valid=0, triggered=0. A following arm captures fresh, fill starting at 0.
- reset_n=0 for 1 clk during ARMED -> all outputs at reset values. A trigger sample next cycle is not captured until arm is pulsed.
- Flags byte: write cycle (rnw=0, sync=0) -> 8'h00; opcode fetch (rnw=1, sync=1) -> 8'hC0. trig_mask=16'h0000 triggers on the first post-arm sample.

Source files
------------

// File: rtl/bus_trace_capture.sv
// Bus-cycle logic analyser: keeps pre-trigger history in a circular RAM, captures a
// post-trigger window, then streams the record oldest-first, four bytes per entry.
module bus_trace_capture #(
  parameter int DEPTH_LOG2   = 9,
  parameter int POST_SAMPLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clken,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_data,
  input  logic        bus_rnw,
  input  logic        bus_sync,
  input  logic        arm,
  input  logic        abort,
  input  logic [15:0] trig_addr,
  input  logic [15:0] trig_mask,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        triggered,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FILL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] POST_INIT = DEPTH_LOG2'(POST_SAMPLES);
  localparam logic [DEPTH_LOG2-1:0] POST_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DUMP} state_t;

  state_t                state_q, state_d;
  logic [25:0]           mem [DEPTH];
  logic [25:0]           rd_q;
  logic [25:0]           ent;
  logic [DEPTH_LOG2-1:0] wr_ptr, wr_inc, rd_ptr, start, post_cnt;
  logic [DEPTH_LOG2:0]   fill, fill_inc, to_load;
  logic [1:0]            bidx;
  logic                  ent_vld, pf_ok;
  logic                  cap, hit, fire, load, dump_done;

  // Stream handshake: a byte transfers on a clk edge where out_valid && out_ready;
  // out_data and out_valid hold unchanged until that edge.
  assign out_valid = ent_vld;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  assign cap       = reset_n && !abort && clken && (state_q == S_ARMED || state_q == S_POST);
  assign hit       = (((bus_addr ^ trig_addr) & trig_mask) == 16'h0000);
  assign wr_inc    = wr_ptr + 1'b1;
  assign fill_inc  = (fill == FILL_FULL) ? fill : fill + 1'b1;
  assign start     = (fill_inc == FILL_FULL) ? wr_inc : '0;
  assign fire      = ent_vld && out_ready;
  // pf_ok means rd_q already holds the entry addressed by rd_ptr.
  assign load      = (state_q == S_DUMP) && (to_load != '0) && pf_ok &&
                     (!ent_vld || (fire && bidx == 2'd3));
  assign dump_done = (state_q == S_DUMP) && fire && (bidx == 2'd3) && (to_load == '0);

  always_comb begin
    out_data = 8'h00;
    case (bidx)
      2'd0:    out_data = ent[25:18];
      2'd1:    out_data = ent[17:10];
      2'd2:    out_data = ent[9:2];
      default: out_data = {ent[0], ent[1], 6'b000000};
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm) state_d = S_ARMED;
      S_ARMED: if (cap && hit) state_d = (POST_SAMPLES == 0) ? S_DUMP : S_POST;
      S_POST:  if (cap && post_cnt == POST_ONE) state_d = S_DUMP;
      S_DUMP:  if (dump_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (cap) mem[wr_ptr] <= {bus_addr, bus_data, bus_rnw, bus_sync};
    rd_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      fill      <= '0;
      post_cnt  <= '0;
      rd_ptr    <= '0;
      to_load   <= '0;
      pf_ok     <= 1'b0;
      ent       <= '0;
      ent_vld   <= 1'b0;
      bidx      <= '0;
      triggered <= 1'b0;
    end else begin
      triggered <= (state_d == S_POST) || (state_d == S_DUMP);
      if (abort) begin
        ent_vld <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (arm) begin
              wr_ptr <= '0;
              fill   <= '0;
            end
          end
          S_ARMED, S_POST: begin
            if (cap) begin
              wr_ptr <= wr_inc;
              fill   <= fill_inc;
              if (state_q == S_ARMED) post_cnt <= POST_INIT;
              else                    post_cnt <= post_cnt - 1'b1;
              if (state_d == S_DUMP) begin
                rd_ptr  <= start;
                pf_ok   <= 1'b0;
                to_load <= fill_inc;
                ent_vld <= 1'b0;
                bidx    <= '0;
              end
            end
          end
          S_DUMP: begin
            if (load) begin
              ent     <= rd_q;
              ent_vld <= 1'b1;
              bidx    <= '0;
              rd_ptr  <= rd_ptr + 1'b1;
              pf_ok   <= 1'b0;
              to_load <= to_load - 1'b1;
            end else begin
              pf_ok <= 1'b1;
              if (fire) begin
                if (bidx == 2'd3) ent_vld <= 1'b0;
                else              bidx    <= bidx + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_trace_capture.sv
// Directed bench: dut_a (512 entries, 2 post samples) and dut_b (16 entries,
// 3 post samples) share the bus; each has its own arm/abort/ready.
module tb_bus_trace_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b0;
  logic [15:0] bus_addr = '0;
  logic [7:0]  bus_data = '0;
  logic        bus_rnw = 1'b0;
  logic        bus_sync = 1'b0;
  logic [15:0] trig_addr = '0;
  logic [15:0] trig_mask = '0;
  logic        arm_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
  logic        arm_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
  logic [7:0]  od_a, od_b;
  logic        ov_a, ov_b, busy_a, busy_b, trg_a, trg_b;
  logic [1:0]  st_a, st_b;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bus_trace_capture #(.DEPTH_LOG2(9), .POST_SAMPLES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .clken(clken), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_rnw(bus_rnw), .bus_sync(bus_sync), .arm(arm_a), .abort(abort_a),
    .trig_addr(trig_addr), .trig_mask(trig_mask), .out_data(od_a), .out_valid(ov_a),
    .out_ready(ready_a), .busy(busy_a), .triggered(trg_a), .dbg_state(st_a));

  bus_trace_capture #(.DEPTH_LOG2(4), .POST_SAMPLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .clken(clken), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_rnw(bus_rnw), .bus_sync(bus_sync), .arm(arm_b), .abort(abort_b),
    .trig_addr(trig_addr), .trig_mask(trig_mask), .out_data(od_b), .out_valid(ov_b),
    .out_ready(ready_b), .busy(busy_b), .triggered(trg_b), .dbg_state(st_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [15:0] a, input logic [7:0] d, input logic rnw, input logic sync);
    bus_addr = a; bus_data = d; bus_rnw = rnw; bus_sync = sync; clken = 1'b1;
    tick();
    clken = 1'b0;
  endtask

  task automatic push_entry(input logic [15:0] a, input logic [7:0] d, input logic rnw, input logic sync);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(d);
    exp_q.push_back({sync, rnw, 6'b000000});
  endtask

  task automatic pulse_arm(input bit sel);
    if (sel) arm_b = 1'b1; else arm_a = 1'b1;
    tick();
    arm_a = 1'b0; arm_b = 1'b0;
  endtask

  task automatic pulse_abort(input bit sel);
    if (sel) abort_b = 1'b1; else abort_a = 1'b1;
    tick();
    abort_a = 1'b0; abort_b = 1'b0;
  endtask

  // Drains one dump into got_q; stall_mode toggles ready every 3 clk and checks hold.
  task automatic collect(input bit sel, input bit stall_mode, input string name,
                         output int cycles, output int first_valid);
    logic       v, r, stalled, done;
    logic [7:0] d, held;
    got_q.delete();
    stalled = 1'b0; done = 1'b0; held = '0;
    first_valid = -1; cycles = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      v = sel ? ov_b : ov_a;
      d = sel ? od_b : od_a;
      r = stall_mode ? (((cyc / 3) % 2) == 0) : 1'b1;
      if (sel) ready_b = r; else ready_a = r;
      if (stalled) begin
        checks++;
        if (v !== 1'b1 || d !== held) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b data=%h, required valid=1 data=%h", name, v, d, held);
        end
      end
      if (v === 1'b1 && first_valid < 0) first_valid = cyc;
      if (v === 1'b1 && r) got_q.push_back(d);
      stalled = (v === 1'b1) && !r;
      held = d;
      tick();
      if ((sel ? busy_b : busy_a) === 1'b0) begin
        done = 1'b1;
        cycles = cyc + 1;
        break;
      end
    end
    ready_a = 1'b0; ready_b = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s dump_timeout: busy still high after 2000 clk, required idle", name);
    end
    checks++;
    if ((sel ? ov_b : ov_a) !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_after_dump: got %b, required 0", name, sel ? ov_b : ov_a);
    end
  endtask

  task automatic compare_stream(input string name);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s byte_count: got %0d, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s byte[%0d]: got %h, required %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_idle(input bit sel, input string name);
    checks++;
    if ((sel ? busy_b : busy_a) !== 1'b0 || (sel ? ov_b : ov_a) !== 1'b0 ||
        (sel ? trg_b : trg_a) !== 1'b0 || (sel ? st_b : st_a) !== 2'd0) begin
      errors++;
      $display("FAIL %s idle: busy=%b valid=%b trig=%b state=%0d, required 0 0 0 0", name,
               sel ? busy_b : busy_a, sel ? ov_b : ov_a, sel ? trg_b : trg_a, sel ? st_b : st_a);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    check_idle(0, "reset_a");
    check_idle(1, "reset_b");
    checks++;
    if (od_a !== 8'h00 || od_b !== 8'h00) begin
      errors++;
      $display("FAIL reset out_data: got %h/%h, required 00/00", od_a, od_b);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic feed_basic();
    trig_addr = 16'hC000; trig_mask = 16'hFFFF;
    exp_q.delete();
    pulse_arm(0);
    for (int n = 0; n < 9; n++) begin
      send_sample(16'(n), 8'h10 + 8'(n), 1'b1, 1'b0);
      push_entry(16'(n), 8'h10 + 8'(n), 1'b1, 1'b0);
    end
    send_sample(16'hC000, 8'hA5, 1'b1, 1'b1);
    push_entry(16'hC000, 8'hA5, 1'b1, 1'b1);
    checks++;
    if (trg_a !== 1'b1 || st_a !== 2'd2) begin
      errors++;
      $display("FAIL basic trigger: trig=%b state=%0d, required 1 2", trg_a, st_a);
    end
    send_sample(16'hD000, 8'h33, 1'b0, 1'b0);
    push_entry(16'hD000, 8'h33, 1'b0, 1'b0);
    send_sample(16'hD001, 8'h44, 1'b1, 1'b0);
    push_entry(16'hD001, 8'h44, 1'b1, 1'b0);
    checks++;
    if (st_a !== 2'd3 || trg_a !== 1'b1) begin
      errors++;
      $display("FAIL basic enter_dump: state=%0d trig=%b, required 3 1", st_a, trg_a);
    end
  endtask

  task automatic test_basic();
    int cycles, first_valid;
    feed_basic();
    collect(0, 1'b0, "basic", cycles, first_valid);
    compare_stream("basic");
    checks++;
    if (first_valid < 0 || first_valid > 3) begin
      errors++;
      $display("FAIL basic first_valid_latency: got %0d clk, required <= 3", first_valid);
    end
    checks++;
    if (cycles > 48 + 12 + 3) begin
      errors++;
      $display("FAIL basic throughput: got %0d clk, required <= 63", cycles);
    end
    check_idle(0, "basic_end");
  endtask

  task automatic test_back_to_back();
    int cycles, first_valid;
    feed_basic();
    collect(0, 1'b1, "backpressure", cycles, first_valid);
    compare_stream("backpressure");
  endtask

  task automatic test_wrap();
    logic [15:0] sa[44];
    logic [7:0]  sd[44];
    logic        sr[44], ss[44];
    int cycles, first_valid;
    for (int i = 0; i < 40; i++) begin
      sa[i] = 16'(i); sd[i] = 8'(i) ^ 8'h5A; sr[i] = 1'b1; ss[i] = 1'b0;
    end
    sa[40] = 16'h1234; sd[40] = 8'hEE; sr[40] = 1'b1; ss[40] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sa[41+k] = 16'h2000 + 16'(k); sd[41+k] = 8'(k); sr[41+k] = 1'b0; ss[41+k] = 1'b0;
    end
    trig_addr = 16'h1234; trig_mask = 16'hFFFF;
    exp_q.delete();
    for (int i = 28; i < 44; i++) push_entry(sa[i], sd[i], sr[i], ss[i]);
    pulse_arm(1);
    for (int i = 0; i < 44; i++) begin
      send_sample(sa[i], sd[i], sr[i], ss[i]);
      if (i == 39) begin
        checks++;
        if (trg_b !== 1'b0) begin
          errors++;
          $display("FAIL wrap early_trigger: got %b, required 0", trg_b);
        end
      end
    end
    checks++;
    if (st_b !== 2'd3) begin
      errors++;
      $display("FAIL wrap enter_dump: state=%0d, required 3", st_b);
    end
    collect(1, 1'b0, "wrap", cycles, first_valid);
    compare_stream("wrap");
  endtask

  task automatic test_abort();
    int cycles, first_valid;
    trig_addr = 16'hC000; trig_mask = 16'hFFFF;
    pulse_arm(0);
    send_sample(16'h0100, 8'h01, 1'b1, 1'b0);
    send_sample(16'hC000, 8'h02, 1'b1, 1'b0);
    send_sample(16'h0200, 8'h03, 1'b1, 1'b0);
    pulse_abort(0);
    check_idle(0, "abort_post");
    pulse_arm(0);
    send_sample(16'h0A00, 8'h04, 1'b1, 1'b0);
    send_sample(16'hC000, 8'h05, 1'b1, 1'b0);
    send_sample(16'hD000, 8'h06, 1'b1, 1'b0);
    send_sample(16'hD001, 8'h07, 1'b1, 1'b0);
    ready_a = 1'b0;
    for (int i = 0; i < 10 && ov_a !== 1'b1; i++) tick();
    checks++;
    if (ov_a !== 1'b1) begin
      errors++;
      $display("FAIL abort dump_valid_wait: got %b, required 1", ov_a);
    end
    pulse_abort(0);
    check_idle(0, "abort_dump");
    exp_q.delete();
    pulse_arm(0);
    send_sample(16'h0B00, 8'h11, 1'b0, 1'b0);
    push_entry(16'h0B00, 8'h11, 1'b0, 1'b0);
    send_sample(16'hC000, 8'h12, 1'b1, 1'b1);
    push_entry(16'hC000, 8'h12, 1'b1, 1'b1);
    send_sample(16'h0B01, 8'h13, 1'b1, 1'b0);
    push_entry(16'h0B01, 8'h13, 1'b1, 1'b0);
    send_sample(16'h0B02, 8'h14, 1'b0, 1'b0);
    push_entry(16'h0B02, 8'h14, 1'b0, 1'b0);
    collect(0, 1'b0, "abort_rearm", cycles, first_valid);
    compare_stream("abort_rearm");
  endtask

  task automatic test_reset_armed();
    int cycles, first_valid;
    trig_addr = 16'h1234; trig_mask = 16'hFFFF;
    pulse_arm(1);
    send_sample(16'h0001, 8'h01, 1'b1, 1'b0);
    send_sample(16'h0002, 8'h02, 1'b1, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_idle(1, "reset_armed_b");
    check_idle(0, "reset_armed_a");
    checks++;
    if (od_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_armed out_data: got %h, required 00", od_b);
    end
    send_sample(16'h1234, 8'h99, 1'b1, 1'b1);
    check_idle(1, "reset_no_capture");
    exp_q.delete();
    pulse_arm(1);
    send_sample(16'h1234, 8'hEE, 1'b1, 1'b1);
    push_entry(16'h1234, 8'hEE, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      send_sample(16'h3000 + 16'(k), 8'h20 + 8'(k), 1'b1, 1'b0);
      push_entry(16'h3000 + 16'(k), 8'h20 + 8'(k), 1'b1, 1'b0);
    end
    collect(1, 1'b0, "reset_rearm", cycles, first_valid);
    compare_stream("reset_rearm");
  endtask

  task automatic test_flags();
    int cycles, first_valid;
    trig_addr = 16'hFFFF; trig_mask = 16'h0000;
    exp_q.delete();
    bus_addr = 16'h9999; bus_data = 8'h55; bus_rnw = 1'b1; bus_sync = 1'b1;
    clken = 1'b1; arm_a = 1'b1;
    tick();
    clken = 1'b0; arm_a = 1'b0;
    checks++;
    if (trg_a !== 1'b0 || st_a !== 2'd1) begin
      errors++;
      $display("FAIL flags arm_cycle_capture: trig=%b state=%0d, required 0 1", trg_a, st_a);
    end
    send_sample(16'h4321, 8'h77, 1'b0, 1'b0);
    push_entry(16'h4321, 8'h77, 1'b0, 1'b0);
    checks++;
    if (trg_a !== 1'b1) begin
      errors++;
      $display("FAIL flags mask0_trigger: got %b, required 1", trg_a);
    end
    send_sample(16'hFFFE, 8'h88, 1'b1, 1'b1);
    push_entry(16'hFFFE, 8'h88, 1'b1, 1'b1);
    send_sample(16'h0001, 8'h00, 1'b1, 1'b0);
    push_entry(16'h0001, 8'h00, 1'b1, 1'b0);
    collect(0, 1'b0, "flags", cycles, first_valid);
    compare_stream("flags");
    checks++;
    if (got_q.size() >= 8 && (got_q[3] !== 8'h00 || got_q[7] !== 8'hC0)) begin
      errors++;
      $display("FAIL flags bytes: got %h %h, required 00 c0", got_q[3], got_q[7]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_abort();
    test_reset_armed();
    test_flags();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
